// File: rtl/wb_ext_bridge_if.sv
// rtl/wb_ext_bridge_if.sv - Wishbone-side and ext-side signal bundle for wb_ext_bridge
interface wb_ext_bridge_if;
  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic        ext_valid;
  logic        ext_instruction;
  logic [31:0] ext_address;
  logic [31:0] ext_write_data;
  logic [3:0]  ext_write_strobe;
  logic        ext_ready;
  logic [31:0] ext_read_data;

  // Bridge view: Wishbone slave on one side, ext request master on the other
  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o,
    output ext_valid, ext_instruction, ext_address, ext_write_data, ext_write_strobe,
    input  ext_ready, ext_read_data
  );

  // Environment view: Wishbone master plus the core answering ext requests
  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o,
    input  ext_valid, ext_instruction, ext_address, ext_write_data, ext_write_strobe,
    output ext_ready, ext_read_data
  );
endinterface

// File: rtl/wb_ext_bridge.sv
// rtl/wb_ext_bridge.sv - registered Wishbone classic to ext valid/ready bridge with timeout
module wb_ext_bridge #(
  parameter logic [31:0] BASE_ADDR      = 32'h3000_0000,
  parameter int          WINDOW_BITS    = 24,
  parameter int          TIMEOUT_CYCLES = 255,
  parameter logic [31:0] TIMEOUT_DATA   = 32'hDEAD_BEEF
) (
  input  logic           clk,
  input  logic           reset_n,
  wb_ext_bridge_if.slave bus,
  output logic           timeout_o,
  output logic           busy_o
);

  typedef enum logic [1:0] {IDLE, REQ, ACK, DRAIN} state_e;

  // Last counter value before the request is abandoned
  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_e      state_q;
  logic [15:0] cnt_q;
  logic        we_q;
  logic        ack_q;
  logic        valid_q;
  logic        timeout_q;
  logic        busy_q;
  logic [31:0] dat_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  strb_q;

  logic req_w;
  logic in_window_w;
  logic expire_w;

  assign req_w       = bus.wbs_cyc_i & bus.wbs_stb_i;
  assign in_window_w = (bus.wbs_adr_i[31:WINDOW_BITS] == BASE_ADDR[31:WINDOW_BITS]);
  assign expire_w    = (cnt_q == CNT_LAST);

  // Single FSM; every output comes straight from a register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= 16'd0;
      we_q      <= 1'b0;
      ack_q     <= 1'b0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      busy_q    <= 1'b0;
      dat_q     <= 32'd0;
      addr_q    <= 32'd0;
      wdata_q   <= 32'd0;
      strb_q    <= 4'd0;
    end else begin
      ack_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_w) begin
            busy_q <= 1'b1;
            if (in_window_w) begin
              addr_q  <= bus.wbs_adr_i;
              wdata_q <= bus.wbs_dat_i;
              strb_q  <= bus.wbs_we_i ? bus.wbs_sel_i : 4'b0000;
              we_q    <= bus.wbs_we_i;
              cnt_q   <= 16'd0;
              valid_q <= 1'b1;
              state_q <= REQ;
            end else begin
              // Outside the user window: answer locally, never touch the core
              dat_q   <= 32'd0;
              ack_q   <= 1'b1;
              state_q <= ACK;
            end
          end
        end
        REQ: begin
          if (bus.ext_ready) begin
            dat_q   <= we_q ? 32'd0 : bus.ext_read_data;
            valid_q <= 1'b0;
            ack_q   <= 1'b1;
            state_q <= ACK;
          end else if (expire_w) begin
            dat_q     <= TIMEOUT_DATA;
            timeout_q <= 1'b1;
            valid_q   <= 1'b0;
            ack_q     <= 1'b1;
            state_q   <= ACK;
          end else begin
            cnt_q <= cnt_q + 16'd1;
            // Master gave up: keep the core request alive but owe no ack
            if (!bus.wbs_cyc_i) begin
              state_q <= DRAIN;
            end
          end
        end
        ACK: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        DRAIN: begin
          if (bus.ext_ready) begin
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else if (expire_w) begin
            timeout_q <= 1'b1;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            state_q   <= IDLE;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.wbs_ack_o        = ack_q;
  assign bus.wbs_dat_o        = dat_q;
  assign bus.ext_valid        = valid_q;
  assign bus.ext_instruction  = 1'b0;
  assign bus.ext_address      = addr_q;
  assign bus.ext_write_data   = wdata_q;
  assign bus.ext_write_strobe = strb_q;
  assign timeout_o            = timeout_q;
  assign busy_o               = busy_q;

endmodule

// File: tb/tb_wb_ext_bridge.sv
// tb/tb_wb_ext_bridge.sv - randomized bench for wb_ext_bridge against a per-edge expectation model
module tb_wb_ext_bridge;
  localparam int          TC  = 4;
  localparam logic [31:0] TD  = 32'hDEAD_BEEF;
  localparam int          N   = 8192;
  localparam int          BIG = 1 << 30;

  logic clk;
  logic reset_n;
  logic timeout_o;
  logic busy_o;

  wb_ext_bridge_if bus();

  wb_ext_bridge #(
    .BASE_ADDR     (32'h3000_0000),
    .WINDOW_BITS   (24),
    .TIMEOUT_CYCLES(TC),
    .TIMEOUT_DATA  (TD)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .bus      (bus),
    .timeout_o(timeout_o),
    .busy_o   (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  // Expected outputs after each edge, filled in per transaction
  bit        exp_valid [N];
  bit        exp_ack   [N];
  bit        exp_busy  [N];
  bit [31:0] exp_dat   [N];
  bit [31:0] exp_addr  [N];
  bit [31:0] exp_wdata [N];
  bit [3:0]  exp_strb  [N];
  int        exp_to = BIG;
  bit        chk_en = 1'b1;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_vec++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (edge %0d)", nm, act, want, edge_n);
    end
  endtask

  // Per-cycle comparison against the model
  always @(negedge clk) begin : cmp
    int k;
    k = edge_n;
    if (chk_en && k < N) begin
      chk("busy_o", 32'(busy_o), 32'(exp_busy[k]));
      chk("ext_valid", 32'(bus.ext_valid), 32'(exp_valid[k]));
      chk("wbs_ack_o", 32'(bus.wbs_ack_o), 32'(exp_ack[k]));
      chk("timeout_o", 32'(timeout_o), 32'(k >= exp_to));
      chk("ext_instruction", 32'(bus.ext_instruction), 32'd0);
      if (exp_valid[k]) begin
        chk("ext_address", bus.ext_address, exp_addr[k]);
        chk("ext_write_data", bus.ext_write_data, exp_wdata[k]);
        chk("ext_write_strobe", 32'(bus.ext_write_strobe), 32'(exp_strb[k]));
      end
      if (exp_ack[k]) chk("wbs_dat_o", bus.wbs_dat_o, exp_dat[k]);
    end
  end

  // Observations used by the literal checks
  int          vrun = 0, last_vlen = 0, n_vrise = 0, ack_cnt = 0, last_ack_edge = 0;
  logic [31:0] last_dat = 0, last_vaddr = 0, last_vwdata = 0;
  logic [3:0]  last_vstrb = 0;
  always @(negedge clk) begin
    if (bus.ext_valid) begin
      if (vrun == 0) n_vrise++;
      vrun++;
      last_vaddr  = bus.ext_address;
      last_vwdata = bus.ext_write_data;
      last_vstrb  = bus.ext_write_strobe;
    end else if (vrun != 0) begin
      last_vlen = vrun;
      vrun      = 0;
    end
    if (bus.wbs_ack_o) begin
      ack_cnt++;
      last_dat      = bus.wbs_dat_o;
      last_ack_edge = edge_n;
    end
  end

  // Drive one Wishbone access; d = ready delay in REQ cycles, j = abort cycle (-1 none)
  task automatic run_txn(input bit win, input bit we, input logic [31:0] adr, input logic [31:0] wd,
                         input logic [3:0] sel, input int d, input int j, input bit hold,
                         input logic [31:0] rd, output int s);
    int dd, a_e, e_e;
    bit timed, abrt;
    s     = edge_n + 1;
    timed = win && (d >= TC);
    dd    = (d < TC) ? d : TC - 1;
    abrt  = win && (j >= 0) && (j < dd);
    a_e   = -10;
    bus.wbs_cyc_i = 1'b1;
    bus.wbs_stb_i = 1'b1;
    bus.wbs_we_i  = we;
    bus.wbs_sel_i = sel;
    bus.wbs_adr_i = adr;
    bus.wbs_dat_i = wd;
    if (!win) begin
      exp_busy[s] = 1'b1;
      exp_ack[s]  = 1'b1;
      exp_dat[s]  = 32'd0;
      a_e = s;
      e_e = s + 1;
    end else begin
      for (int k = s; k <= s + dd; k++) begin
        exp_valid[k] = 1'b1;
        exp_busy[k]  = 1'b1;
        exp_addr[k]  = adr;
        exp_wdata[k] = wd;
        exp_strb[k]  = we ? sel : 4'h0;
      end
      if (abrt) begin
        e_e = s + 1 + dd;
      end else begin
        exp_busy[s + 1 + dd] = 1'b1;
        exp_ack[s + 1 + dd]  = 1'b1;
        exp_dat[s + 1 + dd]  = timed ? TD : (we ? 32'd0 : rd);
        a_e = s + 1 + dd;
        e_e = s + 2 + dd;
      end
      if (timed && exp_to > s + 1 + dd) exp_to = s + 1 + dd;
    end
    for (int k = s; k <= e_e; k++) begin
      @(negedge clk);
      bus.ext_ready     = win && !timed && (k == s + d);
      bus.ext_read_data = bus.ext_ready ? rd : $urandom;
      if (abrt && k == s + j) begin
        bus.wbs_cyc_i = 1'b0;
        bus.wbs_stb_i = 1'b0;
      end
      if (!abrt && k == (hold ? a_e + 1 : a_e)) begin
        bus.wbs_cyc_i = 1'b0;
        bus.wbs_stb_i = 1'b0;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got hang, expected $finish");
    $fatal(1);
  end

  initial begin
    int s, snap, d, j, dd, gap;
    bit win, we, hold;
    logic [31:0] adr;
    logic [7:0]  hi;

    reset_n = 1'b0;
    bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0; bus.wbs_we_i = 1'b0;
    bus.wbs_sel_i = 4'h0; bus.wbs_adr_i = 32'h0; bus.wbs_dat_i = 32'h0;
    bus.ext_ready = 1'b0; bus.ext_read_data = 32'h0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("lit_reset_dat", bus.wbs_dat_o, 32'd0);
    chk("lit_reset_addr", bus.ext_address, 32'd0);

    run_txn(1, 0, 32'h3000_0010, 32'h0, 4'hF, 3, -1, 0, 32'h1234_5678, s);
    @(negedge clk);
    chk("lit_rd_dat", last_dat, 32'h1234_5678);
    chk("lit_rd_addr", last_vaddr, 32'h3000_0010);
    chk("lit_rd_strb", 32'(last_vstrb), 32'h0);
    chk("lit_rd_vlen", 32'(last_vlen), 32'd4);

    run_txn(1, 1, 32'h3000_0004, 32'hA5A5_A5A5, 4'b0110, 0, -1, 1, 32'hFFFF_FFFF, s);
    @(negedge clk);
    chk("lit_wr_strb", 32'(last_vstrb), 32'h6);
    chk("lit_wr_wdata", last_vwdata, 32'hA5A5_A5A5);
    chk("lit_wr_lat", 32'(last_ack_edge - s), 32'd1);
    chk("lit_wr_dat", last_dat, 32'd0);

    snap = n_vrise;
    run_txn(0, 0, 32'h2000_0000, 32'h0, 4'hF, 0, -1, 1, 32'h0, s);
    @(negedge clk);
    chk("lit_oow_lat", 32'(last_ack_edge - s), 32'd0);
    chk("lit_oow_dat", last_dat, 32'd0);
    chk("lit_oow_novalid", 32'(n_vrise), 32'(snap));

    run_txn(1, 0, 32'h3000_0020, 32'h0, 4'hF, 99, -1, 0, 32'h0, s);
    @(negedge clk);
    chk("lit_to_vlen", 32'(last_vlen), 32'd4);
    chk("lit_to_dat", last_dat, 32'hDEAD_BEEF);
    chk("lit_to_sticky", 32'(timeout_o), 32'd1);
    chk("lit_to_lat", 32'(last_ack_edge - s), 32'd4);

    snap = ack_cnt;
    run_txn(1, 0, 32'h3000_0030, 32'h0, 4'hF, 3, 1, 0, 32'h7777_0000, s);
    @(negedge clk);
    chk("lit_abort_noack", 32'(ack_cnt), 32'(snap));
    chk("lit_abort_idle", 32'(busy_o), 32'd0);
    run_txn(1, 0, 32'h3000_0040, 32'h0, 4'hF, 1, -1, 0, 32'h5555_AAAA, s);
    @(negedge clk);
    chk("lit_after_abort_dat", last_dat, 32'h5555_AAAA);

    for (int t = 0; t < 150; t++) begin
      gap = $urandom_range(0, 3);
      repeat (gap) @(negedge clk);
      win = ($urandom_range(0, 4) != 0);
      we  = 1'($urandom_range(0, 1));
      hi  = 8'($urandom);
      if (hi == 8'h30) hi = 8'h31;
      adr = win ? {8'h30, 24'($urandom)} : {hi, 24'($urandom)};
      d   = $urandom_range(0, 6);
      dd  = (d < TC) ? d : TC - 1;
      j   = -1;
      if (win && dd >= 1 && $urandom_range(0, 3) == 0) j = $urandom_range(0, dd - 1);
      hold = 1'($urandom_range(0, 1));
      run_txn(win, we, adr, $urandom, 4'($urandom), d, j, hold, $urandom, s);
    end
    @(negedge clk);
    chk("lit_sticky_end", 32'(timeout_o), 32'd1);

    chk_en = 1'b0;
    bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_we_i = 1'b0;
    bus.wbs_adr_i = 32'h3000_0100;
    @(negedge clk);
    chk("lit_rst_pre_valid", 32'(bus.ext_valid), 32'd1);
    @(negedge clk);
    bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    chk("lit_rst_async_valid", 32'(bus.ext_valid), 32'd0);
    chk("lit_rst_async_busy", 32'(busy_o), 32'd0);
    chk("lit_rst_async_timeout", 32'(timeout_o), 32'd0);
    repeat (2) begin
      @(negedge clk);
      chk("lit_rst_noack", 32'(bus.wbs_ack_o), 32'd0);
    end
    reset_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("lit_postrst_noack", 32'(bus.wbs_ack_o), 32'd0);
      chk("lit_postrst_busy", 32'(busy_o), 32'd0);
    end
    exp_to = BIG;
    chk_en = 1'b1;

    run_txn(1, 0, 32'h3000_0050, 32'h0, 4'hF, 3, -1, 0, 32'h0BAD_F00D, s);
    @(negedge clk);
    chk("lit_ready_last_dat", last_dat, 32'h0BAD_F00D);
    chk("lit_ready_last_noto", 32'(timeout_o), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
